program_counter: RTL and testbench

- Hack-style program counter feeding the instruction ROM address.
- Consumes the 16-bit Register output holding the A value as its jump target.
- Evaluates C-instruction jump bits against ALU flags, supports stall and synchronous soft reset, detects the terminating "jump-to-self" loop, and counts retired instructions.

---
 rtl/program_counter.sv | 126 ++++++++++++
 tb/tb_program_counter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Hack-style program counter: drives the instruction ROM address, loads the
// A register value on a taken C-instruction jump, supports stall and a
// synchronous soft reset, parks in HALT on the unconditional jump-to-self
// idiom, and keeps a saturating count of retired instructions.
module program_counter #(
    parameter int WIDTH       = 16,
    parameter bit HALT_DETECT = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] A,
    input  logic [2:0]       jump,
    input  logic             is_c,
    input  logic             zr,
    input  logic             ng,
    input  logic             stall,
    input  logic             soft_rst,
    input  logic             resume,
    output logic [WIDTH-1:0] Q,
    output logic             taken,
    output logic             halted,
    output logic [WIDTH-1:0] retired
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

    state_t           state_r;
    logic [WIDTH-1:0] q_r;
    logic             taken_r;
    logic             halted_r;
    logic [WIDTH-1:0] retired_r;

    logic             cond_s;
    logic             halt_hit_s;
    logic [WIDTH-1:0] q_inc_s;
    logic [WIDTH-1:0] retired_inc_s;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        if (v == ONES_W) begin
            return v;
        end else begin
            return v + ONE_W;
        end
    endfunction

    // Jump decision, jump-to-self halt detection and next-address arithmetic.
    always_comb begin
        cond_s        = is_c & ((jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr));
        halt_hit_s    = HALT_DETECT & cond_s & (jump == 3'b111) & (A == q_r);
        q_inc_s       = q_r + ONE_W;
        retired_inc_s = sat_inc(retired_r);
    end

    // PC state machine; every output comes straight from a register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r   <= RUN;
            q_r       <= ZERO_W;
            taken_r   <= 1'b0;
            halted_r  <= 1'b0;
            retired_r <= ZERO_W;
        end else if (soft_rst) begin
            // Soft reset wins over stall, resume and HALT.
            state_r   <= RUN;
            q_r       <= ZERO_W;
            taken_r   <= 1'b0;
            halted_r  <= 1'b0;
            retired_r <= ZERO_W;
        end else begin
            case (state_r)
                RUN: begin
                    if (stall) begin
                        q_r       <= q_r;
                        taken_r   <= taken_r;
                        retired_r <= retired_r;
                    end else if (halt_hit_s) begin
                        // Program's terminating loop: park without retiring.
                        state_r  <= HALT;
                        halted_r <= 1'b1;
                        taken_r  <= 1'b1;
                    end else if (cond_s) begin
                        q_r       <= A;
                        taken_r   <= 1'b1;
                        retired_r <= retired_inc_s;
                    end else begin
                        q_r       <= q_inc_s;
                        taken_r   <= 1'b0;
                        retired_r <= retired_inc_s;
                    end
                end
                HALT: begin
                    if (resume && !stall) begin
                        state_r   <= RUN;
                        halted_r  <= 1'b0;
                        q_r       <= q_inc_s;
                        taken_r   <= 1'b0;
                        retired_r <= retired_inc_s;
                    end else begin
                        state_r   <= HALT;
                        halted_r  <= 1'b1;
                        q_r       <= q_r;
                        retired_r <= retired_r;
                    end
                end
                default: begin
                    state_r  <= RUN;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign Q       = q_r;
    assign taken   = taken_r;
    assign halted  = halted_r;
    assign retired = retired_r;

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: three instances (16-bit with halt detection,
// 4-bit for saturation/wrap, 16-bit without halt detection) share stimulus.
// A per-instance behavioural model is compared on every falling edge, and
// directed literal expectations pin the model.
module tb_program_counter;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [15:0] A;
    logic [2:0]  jump;
    logic        is_c, zr, ng, stall, soft_rst, resume;

    logic [15:0] q0, rt0, q2, rt2;
    logic [3:0]  q1, rt1;
    logic        tk0, hl0, tk1, hl1, tk2, hl2;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] ret;
        logic        taken;
        logic        halted;
    } mst_t;

    mst_t m [3];
    int   wid [3] = '{16, 4, 16};
    bit   hdet [3] = '{1'b1, 1'b1, 1'b0};

    always #5 CLK = ~CLK;

    program_counter #(.WIDTH(16), .HALT_DETECT(1'b1)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .A(A), .jump(jump), .is_c(is_c), .zr(zr), .ng(ng),
        .stall(stall), .soft_rst(soft_rst), .resume(resume),
        .Q(q0), .taken(tk0), .halted(hl0), .retired(rt0));

    program_counter #(.WIDTH(4), .HALT_DETECT(1'b1)) dut4 (
        .CLK(CLK), .RESET_N(RESET_N), .A(A[3:0]), .jump(jump), .is_c(is_c), .zr(zr), .ng(ng),
        .stall(stall), .soft_rst(soft_rst), .resume(resume),
        .Q(q1), .taken(tk1), .halted(hl1), .retired(rt1));

    program_counter #(.WIDTH(16), .HALT_DETECT(1'b0)) dut_nh (
        .CLK(CLK), .RESET_N(RESET_N), .A(A), .jump(jump), .is_c(is_c), .zr(zr), .ng(ng),
        .stall(stall), .soft_rst(soft_rst), .resume(resume),
        .Q(q2), .taken(tk2), .halted(hl2), .retired(rt2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural next state from the instruction-level rules.
    function automatic mst_t model_next(input mst_t s, input int w, input bit hd);
        mst_t        n;
        logic [31:0] mask;
        logic [31:0] a;
        bit          cnd;
        n    = s;
        mask = (32'd1 << w) - 32'd1;
        a    = {16'h0000, A} & mask;
        cnd  = is_c && ((jump[2] && ng) || (jump[1] && zr) || (jump[0] && !ng && !zr));
        if (soft_rst) begin
            n = '{32'd0, 32'd0, 1'b0, 1'b0};
        end else if (s.halted) begin
            if (resume && !stall) begin
                n.q      = (s.q + 32'd1) & mask;
                n.taken  = 1'b0;
                n.halted = 1'b0;
                n.ret    = (s.ret == mask) ? s.ret : s.ret + 32'd1;
            end
        end else if (!stall) begin
            if (hd && cnd && jump == 3'b111 && a == s.q) begin
                n.halted = 1'b1;
                n.taken  = 1'b1;
            end else begin
                n.q     = cnd ? a : ((s.q + 32'd1) & mask);
                n.taken = cnd;
                n.ret   = (s.ret == mask) ? s.ret : s.ret + 32'd1;
            end
        end
        return n;
    endfunction

    // Model state advances on the same events as the DUTs.
    always @(posedge CLK or negedge RESET_N) begin
        for (int i = 0; i < 3; i++) begin
            if (!RESET_N) m[i] <= '{32'd0, 32'd0, 1'b0, 1'b0};
            else          m[i] <= model_next(m[i], wid[i], hdet[i]);
        end
    end

    // Compare every instance against the model away from the active edge.
    always @(negedge CLK) begin
        mst_t act [3];
        act[0] = '{32'(q0), 32'(rt0), tk0, hl0};
        act[1] = '{32'(q1), 32'(rt1), tk1, hl1};
        act[2] = '{32'(q2), 32'(rt2), tk2, hl2};
        for (int i = 0; i < 3; i++) begin
            check($sformatf("model%0d.Q", i),       act[i].q,            m[i].q);
            check($sformatf("model%0d.retired", i), act[i].ret,          m[i].ret);
            check($sformatf("model%0d.taken", i),   32'(act[i].taken),   32'(m[i].taken));
            check($sformatf("model%0d.halted", i),  32'(act[i].halted),  32'(m[i].halted));
        end
    end

    task automatic drive(input logic [15:0] a, input logic [2:0] j, input logic c,
                         input logic z, input logic n, input logic st,
                         input logic sr, input logic rs);
        A = a; jump = j; is_c = c; zr = z; ng = n; stall = st; soft_rst = sr; resume = rs;
    endtask

    task automatic step(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic idle();
        drive(16'h0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic jmp(input logic [15:0] a);
        drive(a, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        RESET_N = 1'b0;
        idle();
        #3;
        check("reset_q", 32'(q0), 32'h0);
        check("reset_retired", 32'(rt0), 32'h0);
        check("reset_taken_halted", {30'd0, tk0, hl0}, 32'h0);
        #4 RESET_N = 1'b1;
        step(3);
        check("run3_q", 32'(q0), 32'h3);
        check("run3_retired", 32'(rt0), 32'h3);

        jmp(16'h0123); step(1);
        check("jmp123_q", 32'(q0), 32'h0123);
        check("jmp123_taken", 32'(tk0), 32'h1);

        // Asynchronous reset between edges.
        idle();
        RESET_N = 1'b0;
        #1;
        check("async_q", 32'(q0), 32'h0);
        check("async_retired", 32'(rt0), 32'h0);
        check("async_halted", 32'(hl0), 32'h0);
        #1 RESET_N = 1'b1;
        step(3);
        check("post_async_q", 32'(q0), 32'h3);
        check("post_async_retired", 32'(rt0), 32'h3);

        jmp(16'h0010); step(1);
        drive(16'h0040, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step(1);
        check("jeq_q", 32'(q0), 32'h0040);
        check("jeq_taken", 32'(tk0), 32'h1);
        jmp(16'h0010); step(1);
        drive(16'h0040, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step(1);
        check("jgt_q", 32'(q0), 32'h0040);
        jmp(16'h0010); step(1);
        drive(16'h0040, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); step(1);
        check("jgt_not_q", 32'(q0), 32'h0011);
        check("jgt_not_taken", 32'(tk0), 32'h0);
        check("jgt_not_retired", 32'(rt0), 32'd9);

        jmp(16'h0005); step(1);
        drive(16'h0077, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("stall_q", 32'(q0), 32'h0005);
            check("stall_retired", 32'(rt0), 32'd10);
            check("stall_taken", 32'(tk0), 32'h1);
        end
        drive(16'h0077, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); step(1);
        check("srst_q", 32'(q0), 32'h0);
        check("srst_retired", 32'(rt0), 32'h0);
        check("srst_taken", 32'(tk0), 32'h0);

        jmp(16'h0020); step(1);
        jmp(16'h0020); step(1);
        check("halt_enter", 32'(hl0), 32'h1);
        check("halt_q", 32'(q0), 32'h0020);
        check("halt_retired", 32'(rt0), 32'h1);
        check("halt_taken", 32'(tk0), 32'h1);
        check("nh_self_halted", 32'(hl2), 32'h0);
        check("nh_self_q", 32'(q2), 32'h0020);
        check("nh_self_retired", 32'(rt2), 32'h2);
        jmp(16'h0099);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("halt_hold_q", 32'(q0), 32'h0020);
            check("halt_hold_halted", 32'(hl0), 32'h1);
        end
        check("nh_run_q", 32'(q2), 32'h0099);
        check("nh_run_retired", 32'(rt2), 32'd7);
        drive(16'h0099, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); step(1);
        check("resume_stalled", 32'(hl0), 32'h1);
        drive(16'h0099, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); step(1);
        check("resume_q", 32'(q0), 32'h0021);
        check("resume_halted", 32'(hl0), 32'h0);
        check("resume_retired", 32'(rt0), 32'h2);

        jmp(16'hFFFF); step(1);
        check("ffff_q", 32'(q0), 32'hFFFF);
        idle(); step(1);
        check("wrap_q", 32'(q0), 32'h0000);
        check("wrap_retired", 32'(rt0), 32'h4);

        step(20);
        check("sat4_retired", 32'(rt1), 32'hF);

        @(negedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
